// File: rtl/data_mem_responder_if.sv
// Load/store port bundle between a CPU requester (master) and a data-memory responder (slave).
// Carries the request handshake, the response handshake and the busy indication.
interface data_mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        busy;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err, busy
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err, busy
    );
endinterface

// File: rtl/data_mem_responder.sv
// Multi-cycle word memory behind a valid/ready load/store port with fixed access latency.
// Define DMEM_MISALIGN_CHECK_EN to flag and suppress accesses with req_addr[1:0] != 0.
module data_mem_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    data_mem_responder_if.slave  bus
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [31:0]        wdata_q, wdata_d;
    logic               write_q, write_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               err_q, err_d;
    logic               mem_we;
    logic               bad;
    logic [31:0]        mem_q [DEPTH];

    // Address bits outside the word index are intentionally ignored (wrap-around).
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.req_addr[31:IDX_W+2], bus.req_addr[1:0]};

`ifdef DMEM_MISALIGN_CHECK_EN
    logic misal_q, misal_d;
    assign bad = misal_q;
`else
    assign bad = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        write_d = write_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        mem_we  = 1'b0;
`ifdef DMEM_MISALIGN_CHECK_EN
        misal_d = misal_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    idx_d   = bus.req_addr[IDX_W+1:2];
                    wdata_d = bus.req_wdata;
                    write_d = bus.req_write;
                    cnt_d   = CNT_W'(LATENCY - 1);
`ifdef DMEM_MISALIGN_CHECK_EN
                    misal_d = (bus.req_addr[1:0] != 2'b00);
`endif
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    mem_we  = write_q & ~bad;
                    rdata_d = (write_q | bad) ? 32'h0 : mem_q[idx_q];
                    err_d   = bad;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                if (bus.resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
`ifdef DMEM_MISALIGN_CHECK_EN
            misal_q <= 1'b0;
`endif
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            write_q <= write_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
`ifdef DMEM_MISALIGN_CHECK_EN
            misal_q <= misal_d;
`endif
            if (mem_we) mem_q[idx_q] <= wdata_q;
        end
    end

    // Handshake outputs come from the state register; reset forces them low.
    assign bus.req_ready  = rst & (state_q == IDLE);
    assign bus.resp_valid = rst & (state_q == RESP);
    assign bus.busy       = rst & (state_q != IDLE);
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;
endmodule
